// File: rtl/spi_pkg.sv
// Shared types and constants for the generic SPI slave front end.
package spi_pkg;

    // Front-end protocol states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

    // Sub-command field carried in the top two bits of every frame.
    localparam logic [1:0] SUB_WR_ADDR = 2'b00;
    localparam logic [1:0] SUB_WR_DATA = 2'b01;
    localparam logic [1:0] SUB_RD_ADDR = 2'b10;
    localparam logic [1:0] SUB_RD_DATA = 2'b11;

    // Leading command bit that selects the write or read path.
    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serializer: captures one read word on load and shifts it out one bit per
// clock with an output enable. A clear drops everything at once.
module spi_tx_shifter #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              miso_oe,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shreg_r;
    logic [CNT_W-1:0]  left_r;
    logic              miso_r;
    logic              oe_r;

    logic              first_bit_s;
    logic [DATA_W-1:0] load_rest_s;
    logic              next_bit_s;
    logic [DATA_W-1:0] shifted_s;

    // Select which end of the word leaves first and how the remainder shifts.
    always_comb begin
        first_bit_s = 1'b0;
        load_rest_s = {DATA_W{1'b0}};
        next_bit_s  = 1'b0;
        shifted_s   = {DATA_W{1'b0}};
        if (MSB_FIRST) begin
            first_bit_s = data[DATA_W-1];
            load_rest_s = data << 1'b1;
            next_bit_s  = shreg_r[DATA_W-1];
            shifted_s   = shreg_r << 1'b1;
        end else begin
            first_bit_s = data[0];
            load_rest_s = data >> 1'b1;
            next_bit_s  = shreg_r[0];
            shifted_s   = shreg_r >> 1'b1;
        end
    end

    // Load, shift and retire the read word; MISO idles low when not driving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_r <= {DATA_W{1'b0}};
            left_r  <= CNT_ZERO;
            miso_r  <= 1'b0;
            oe_r    <= 1'b0;
        end else if (clear) begin
            shreg_r <= {DATA_W{1'b0}};
            left_r  <= CNT_ZERO;
            miso_r  <= 1'b0;
            oe_r    <= 1'b0;
        end else if (load) begin
            shreg_r <= load_rest_s;
            left_r  <= CNT_LOAD;
            miso_r  <= first_bit_s;
            oe_r    <= 1'b1;
        end else if (oe_r) begin
            if (left_r != CNT_ZERO) begin
                shreg_r <= shifted_s;
                left_r  <= left_r - CNT_ONE;
                miso_r  <= next_bit_s;
            end else begin
                miso_r <= 1'b0;
                oe_r   <= 1'b0;
            end
        end
    end

    assign miso    = miso_r;
    assign miso_oe = oe_r;
    // High while the final bit of the word is on the line.
    assign done    = oe_r && (left_r == CNT_ZERO);

endmodule

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave front end: deserialises MOSI frames into rx_data and
// returns one controller read word on MISO per read-data frame.
module spi_slave_gen
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              tx_ready,
    output logic              MISO,
    output logic              miso_oe,
    output logic              frame_err,
    output logic              busy
);

    localparam int FW    = DATA_W + 2;
    localparam int CNT_W = $clog2(FW + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FW_C     = CNT_W'(FW);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(FW - 1);

    spi_state_t        state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [FW-1:0]     shreg_r;
    logic [FW-1:0]     rx_data_r;
    logic              rx_valid_r;
    logic              frame_err_r;
    logic              tx_ready_r;
    logic              add_exist_r;
    logic              busy_r;

    logic [FW-1:0]     shift_next_s;
    logic              in_frame_s;
    logic              abort_s;
    logic              load_s;
    logic              tx_done_s;
    logic              miso_s;
    logic              miso_oe_s;

    // Next shift-register value, frame-abort detection and read handshake.
    always_comb begin
        shift_next_s = {FW{1'b0}};
        if (MSB_FIRST) begin
            shift_next_s = {shreg_r[FW-2:0], MOSI};
        end else begin
            shift_next_s = {MOSI, shreg_r[FW-1:1]};
        end
        in_frame_s = (state_r == WRITE) || (state_r == READ_ADD) || (state_r == READ_DATA);
        // A partial payload or a read word still being shifted makes SS_n rising an abort.
        abort_s    = in_frame_s && SS_n &&
                     (((bit_cnt_r != CNT_ZERO) && (bit_cnt_r < FW_C)) ||
                      (miso_oe_s && !tx_done_s));
        load_s     = tx_ready_r && tx_valid && !SS_n;
    end

    // Protocol FSM with registered receive, handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= CNT_ZERO;
            shreg_r     <= {FW{1'b0}};
            rx_data_r   <= {FW{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            tx_ready_r  <= 1'b0;
            add_exist_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= CNT_ZERO;
                    if (!SS_n) begin
                        state_r <= CHK_CMD;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CHK_CMD: begin
                    if (SS_n) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        case (MOSI)
                            CMD_WR:  state_r <= WRITE;
                            CMD_RD:  state_r <= add_exist_r ? READ_DATA : READ_ADD;
                            default: begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (SS_n) begin
                        // SS_n wins over a bit arriving in the same cycle.
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        bit_cnt_r   <= CNT_ZERO;
                        tx_ready_r  <= 1'b0;
                        frame_err_r <= abort_s;
                    end else if (bit_cnt_r < FW_C) begin
                        shreg_r   <= shift_next_s;
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        if (bit_cnt_r == LAST_C) begin
                            rx_data_r  <= shift_next_s;
                            rx_valid_r <= 1'b1;
                            if (state_r == READ_ADD) begin
                                add_exist_r <= 1'b1;
                            end else if (state_r == READ_DATA) begin
                                add_exist_r <= 1'b0;
                                tx_ready_r  <= 1'b1;
                            end
                        end
                    end else if (load_s) begin
                        // One response per frame: the offer closes on handshake.
                        tx_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    spi_tx_shifter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (abort_s),
        .load    (load_s),
        .data    (tx_data),
        .miso    (miso_s),
        .miso_oe (miso_oe_s),
        .done    (tx_done_s)
    );

    assign rx_valid  = rx_valid_r;
    assign rx_data   = rx_data_r;
    assign tx_ready  = tx_ready_r;
    assign MISO      = miso_s;
    assign miso_oe   = miso_oe_s;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: an MSB-first and an LSB-first instance share
// the same pin stimulus; each step checks hand-computed expectations.
module tb_spi_slave_gen;
    import spi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic       rx_valid_m, tx_ready_m, miso_m, oe_m, ferr_m, busy_m;
    logic [9:0] rx_data_m;
    logic       rx_valid_l, tx_ready_l, miso_l, oe_l, ferr_l, busy_l;
    logic [9:0] rx_data_l;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_byte;

    spi_slave_gen #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .tx_valid(tx_valid), .tx_data(tx_data),
        .rx_valid(rx_valid_m), .rx_data(rx_data_m), .tx_ready(tx_ready_m),
        .MISO(miso_m), .miso_oe(oe_m), .frame_err(ferr_m), .busy(busy_m)
    );

    spi_slave_gen #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .tx_valid(tx_valid), .tx_data(tx_data),
        .rx_valid(rx_valid_l), .rx_data(rx_data_l), .tx_ready(tx_ready_l),
        .MISO(miso_l), .miso_oe(oe_l), .frame_err(ferr_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drop SS_n, send the command bit, then the first nbits of v (bit 9 first).
    task automatic frame(input logic cmd, input logic [9:0] v, input int nbits);
        SS_n = 1'b0; MOSI = 1'b0; tick();
        MOSI = cmd; tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = v[9-i]; tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tick(); tick();
        chk("reset_outs_m", {21'd0, rx_valid_m, rx_data_m, tx_ready_m, miso_m, oe_m, ferr_m, busy_m}, 32'd0);
        chk("reset_outs_l", {21'd0, rx_valid_l, rx_data_l, tx_ready_l, miso_l, oe_l, ferr_l, busy_l}, 32'd0);
        chk("reset_state", u_msb.state_r, IDLE);
        rst_n = 1'b1; tick();

        // Write frame: pulse exactly 12 cycles after SS_n fell.
        frame(CMD_WR, {SUB_WR_ADDR, 8'hA5}, 9);
        chk("wr_no_early_valid", rx_valid_m, 1'b0);
        chk("wr_busy", busy_m, 1'b1);
        MOSI = 1'b1; tick();
        chk("wr_valid", rx_valid_m, 1'b1);
        chk("wr_data", rx_data_m, 10'h0A5);
        chk("wr_ferr", ferr_m, 1'b0);
        tick();
        chk("wr_valid_one_pulse", rx_valid_m, 1'b0);
        chk("wr_extra_bits_ignored", rx_data_m, 10'h0A5);
        SS_n = 1'b1; tick();
        chk("wr_end_no_err", ferr_m, 1'b0);
        chk("wr_end_idle", busy_m, 1'b0);

        // Read address, then read data with a 0xC3 response.
        frame(CMD_RD, {SUB_RD_ADDR, 8'h0F}, 10);
        chk("rda_data", rx_data_m, 10'h20F);
        chk("rda_add_exist", u_msb.add_exist_r, 1'b1);
        chk("rda_no_ready", tx_ready_m, 1'b0);
        SS_n = 1'b1; tick();
        frame(CMD_RD, {SUB_RD_DATA, 8'h00}, 10);
        chk("rdd_data", rx_data_m, 10'h300);
        chk("rdd_valid", rx_valid_m, 1'b1);
        chk("rdd_ready", tx_ready_m, 1'b1);
        chk("rdd_add_cleared", u_msb.add_exist_r, 1'b0);
        tx_valid = 1'b1; tx_data = 8'hC3; exp_byte = 8'hC3; tick();
        tx_valid = 1'b0;
        chk("rdd_ready_drop", tx_ready_m, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rdd_miso_bit%0d", k), {30'd0, oe_m, miso_m}, {30'd0, 1'b1, exp_byte[7-k]});
            tick();
        end
        chk("rdd_after_shift", {30'd0, oe_m, miso_m}, 32'd0);
        chk("rdd_single_response", tx_ready_m, 1'b0);
        SS_n = 1'b1; tick();
        chk("rdd_end_no_err", ferr_m, 1'b0);

        // Abort after 5 payload bits of a read-address frame.
        frame(CMD_RD, {SUB_RD_ADDR, 8'hFF}, 5);
        SS_n = 1'b1; tick();
        chk("abort5_ferr", ferr_m, 1'b1);
        chk("abort5_no_valid", rx_valid_m, 1'b0);
        chk("abort5_rx_kept", rx_data_m, 10'h300);
        chk("abort5_add_kept", u_msb.add_exist_r, 1'b0);
        tick();
        chk("abort5_ferr_pulse", ferr_m, 1'b0);
        // SS_n rising together with the last bit is still an abort.
        frame(CMD_RD, {SUB_RD_ADDR, 8'hFF}, 9);
        SS_n = 1'b1; MOSI = 1'b1; tick();
        chk("abort9_ferr", ferr_m, 1'b1);
        chk("abort9_no_valid", rx_valid_m, 1'b0);
        chk("abort9_add_kept", u_msb.add_exist_r, 1'b0);
        tick();

        // Late tx_valid, then abort in the middle of the MISO shift.
        frame(CMD_RD, {SUB_RD_ADDR, 8'h01}, 10);
        chk("late_rda_data", rx_data_m, 10'h201);
        SS_n = 1'b1; tick();
        frame(CMD_RD, {SUB_RD_DATA, 8'h00}, 10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("late_wait%0d", k), {30'd0, tx_ready_m, oe_m}, {30'd0, 1'b1, 1'b0});
            tick();
        end
        tx_valid = 1'b1; tx_data = 8'hA5; tick();
        tx_valid = 1'b0;
        chk("late_first", {30'd0, oe_m, miso_m}, {30'd0, 1'b1, 1'b1});
        tick();
        chk("late_second", {30'd0, oe_m, miso_m}, {30'd0, 1'b1, 1'b0});
        tick();
        SS_n = 1'b1; tick();
        chk("shift_abort_ferr", ferr_m, 1'b1);
        chk("shift_abort_oe", {30'd0, oe_m, miso_m}, 32'd0);
        chk("shift_abort_add", u_msb.add_exist_r, 1'b0);
        tick();

        // LSB-first instance: first received bit lands in rx_data[0].
        frame(CMD_RD, 10'b10_0000_0011, 10);
        chk("lsb_rx_data", rx_data_l, 10'h301);
        chk("lsb_msb_view", rx_data_m, 10'h203);
        SS_n = 1'b1; tick();
        frame(CMD_RD, 10'h000, 10);
        chk("lsb_ready", tx_ready_l, 1'b1);
        tx_valid = 1'b1; tx_data = 8'h01; tick();
        tx_valid = 1'b0;
        chk("lsb_miso_first", {30'd0, oe_l, miso_l}, {30'd0, 1'b1, 1'b1});
        chk("msb_miso_first", {30'd0, oe_m, miso_m}, {30'd0, 1'b1, 1'b0});
        tick();
        chk("lsb_miso_second", {30'd0, oe_l, miso_l}, {30'd0, 1'b1, 1'b0});

        // Synchronous reset in the middle of the MISO shift.
        rst_n = 1'b0; tick();
        chk("rst_mid_outs_m", {21'd0, rx_valid_m, rx_data_m, tx_ready_m, miso_m, oe_m, ferr_m, busy_m}, 32'd0);
        chk("rst_mid_outs_l", {21'd0, rx_valid_l, rx_data_l, tx_ready_l, miso_l, oe_l, ferr_l, busy_l}, 32'd0);
        chk("rst_mid_state", u_lsb.state_r, IDLE);
        chk("rst_mid_add", u_lsb.add_exist_r, 1'b0);
        rst_n = 1'b1; SS_n = 1'b1; tick();
        chk("rst_release_no_err", {30'd0, ferr_m, ferr_l}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_gen.md
# spi_slave_gen

Parametrised SPI slave front end, the next generation of the team's fixed 8-bit SPI slave. It sits between the external SPI pins and the register/RAM controller: it deserialises MOSI frames into `rx_data`/`rx_valid` and serialises controller read data onto MISO. Compared with the previous block it adds:

- configurable data width and bit order
- a `tx_ready`/`tx_valid` handshake
- a MISO output-enable
- frame-abort detection
- an `rx_data` that only changes on completed frames

MOSI and SS_n are sampled on `clk`, one bit per cycle.

## Interface
Parameters:
- `DATA_W`, 8: payload width; the frame is FW = DATA_W+2 bits (2-bit sub-command + payload).
- `MSB_FIRST`, 1: 1 = MSB shifted first on MOSI and MISO; 0 = LSB first.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low; clock `clk`.
- `SS_n`  in  1  slave select, active-low.
- `MOSI`  in  1  serial data in.
- `tx_valid`  in  1  read data offered by controller.
- `tx_data`  in  DATA_W  read data.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds a new completed frame.
- `rx_data`  out  FW  last completed frame, {sub-cmd[1:0], payload}.
- `tx_ready`  out  1  slave accepts `tx_data` this cycle.
- `MISO`  out  1  serial data out.
- `miso_oe`  out  1  high while MISO carries valid read data.
- `frame_err`  out  1  one-cycle pulse on aborted frame.
- `busy`  out  1  high whenever state != IDLE.

## Operation
States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.

Transitions:
- Any state goes to IDLE when SS_n=1 is sampled.
- IDLE goes to CHK_CMD on SS_n=0.
- CHK_CMD samples the MOSI command bit:
  - 0 → WRITE.
  - 1 with `add_exist`=1 → READ_DATA.
  - 1 with `add_exist`=0 → READ_ADD.
- WRITE, READ_ADD and READ_DATA hold until SS_n=1.

Receive path:
- In WRITE, READ_ADD and READ_DATA, MOSI is shifted into an internal shift register while `bit_cnt` < FW; `bit_cnt` increments per bit.
- Bit order follows `MSB_FIRST`. When LSB-first, the first received bit lands in `rx_data[0]`.
- On the FW-th bit: the shift register is copied to `rx_data` and `rx_valid` pulses.
- Further MOSI bits in the same frame are ignored.

`add_exist`:
- Set only on a completed READ_ADD frame.
- Cleared only on a completed READ_DATA frame.
- An aborted frame leaves it unchanged.

Read response (READ_DATA only):
- After frame completion, `tx_ready`=1 until the first cycle with `tx_valid`=1, which captures `tx_data`.
- MISO then shifts DATA_W bits, one per cycle, with `miso_oe`=1.
- After the last bit: `miso_oe`=0 and `MISO`=0.
- Only one response per frame; `tx_ready` stays 0 afterwards.

Abort:
- Applies when SS_n rises in WRITE, READ_ADD or READ_DATA with 0 < `bit_cnt` < FW, or with the MISO shift incomplete.
- Effects: `frame_err` pulses; `rx_valid` is not asserted; `rx_data` is unchanged; the serializer is cleared; `miso_oe`=0.
- SS_n rising in CHK_CMD is not an error.

Reset values:
- All outputs 0, except `rx_data`=0 and `MISO`=0.
- State is IDLE, counters 0, `add_exist`=0.
- Reset mid-frame behaves identically; no `frame_err` is generated.

## Timing
- Cycle n: SS_n=0 in IDLE. Cycle n+1: CHK_CMD samples the command bit. Cycles n+2 … n+1+FW: payload bits.
- `rx_valid` is high in cycle n+2+FW, and `rx_data` is valid in the same cycle.
- `tx_ready` is high from cycle n+2+FW.
- A handshake at cycle t puts the first MISO bit in t+1 and the last in t+DATA_W.
- `frame_err` appears the cycle after SS_n=1 is sampled.
- If SS_n rises in the same cycle the FW-th bit would be sampled, the frame counts as aborted: SS_n has priority.
- `bit_cnt` saturates at FW; there is no wrap.

## Structure
- Package `spi_pkg` holds:
  - the state enum `spi_state_t`;
  - sub-command constants `SUB_WR_ADDR`=2'b00, `SUB_WR_DATA`=2'b01, `SUB_RD_ADDR`=2'b10, `SUB_RD_DATA`=2'b11;
  - the command bit constants `CMD_WR`=0, `CMD_RD`=1.
- Sub-module `spi_tx_shifter` (parameters DATA_W, MSB_FIRST):
  - load/handshake, bit counter, `MISO`, `miso_oe`, `done`, and a `clear` input driven on abort.

## Test plan
All scenarios use DATA_W=8 and MSB_FIRST=1.

1. **Write frame.** Cmd bit 0, then 10'b00_1010_0101 → `rx_valid` one pulse 12 cycles after SS_n fell, `rx_data`=0x0A5, `frame_err`=0.
2. **Read address then read data.**
   - Cmd 1 + 10'b10_0000_1111 → `rx_data`=0x20F, `add_exist`=1.
   - Next frame: cmd 1 + 10'b11_0000_0000, `tx_valid` with 0xC3 → MISO 1,1,0,0,0,0,1,1 with `miso_oe`=1 for 8 cycles; `add_exist`=0.
3. **Abort.** SS_n rises after 5 payload bits → `frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value, `add_exist` unchanged.
4. **Late tx_valid.** `tx_valid` held low 4 cycles after frame completion → `tx_ready` stays 1; MISO starts the cycle after `tx_valid` rises.
5. **LSB first.** MSB_FIRST=0, payload bits 1,0,0,0,0,0,0,0 after sub-cmd → `rx_data[0]`=1; read of 0x01 → MISO first bit 1.
6. **Reset mid-read.** `rst_n`=0 during the MISO shift → next cycle all outputs 0, state IDLE, `add_exist`=0.
